// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - pipeline hazard/forwarding unit with multi-cycle execute hold
// Drives stall, flush, bubble and forward selects; counts stall and branch-flush cycles.
module hazard_unit_mc #(
  parameter int REG_AW   = 3,
  parameter int ZERO_REG = 1,
  parameter int MC_LAT   = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              MultiCycleE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleM,
  output logic              McBusy,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int CW = $clog2(MC_LAT) + 1;
  localparam bit MC_MULTI = (MC_LAT > 1);
  localparam logic [CW-1:0] CNT_INIT = MC_MULTI ? CW'(MC_LAT - 2) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;
  logic              mc_start, mc, lu;

  function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && match(RD_M, rs))      return 2'b10;
    else if (RegWriteW && match(RD_W, rs)) return 2'b01;
    else                                   return 2'b00;
  endfunction

  always_comb begin
    mc_start = (state_q == IDLE) && MultiCycleE && !PCSrcE && MC_MULTI;
    mc       = mc_start || ((state_q == BUSY) && (cnt_q != '0));
    lu       = ResultSrcE && (match(RD_E, Rs1_D) || match(RD_E, Rs2_D));

    ForwardAE = rst ? 2'b00 : fwd_sel(Rs1_E);
    ForwardBE = rst ? 2'b00 : fwd_sel(Rs2_E);
    StallF    = !rst && (mc || lu);
    StallD    = !rst && (mc || lu);
    StallE    = !rst && mc;
    BubbleM   = !rst && mc;
    FlushD    = !rst && PCSrcE;
    // A held multi-cycle op must not be cleared by a load-use flush.
    FlushE    = !rst && (PCSrcE || (lu && !mc));
    McBusy    = !rst && (state_q == BUSY);

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (mc_start) begin
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end
      BUSY: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stall_count_d = stall_count_q;
    if (StallF && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
    flush_count_d = flush_count_q;
    if (FlushD && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - directed self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;

  logic clk = 1'b0;
  logic rst;
  logic RegWriteM, RegWriteW, ResultSrcE, MultiCycleE, PCSrcE;
  logic [2:0] RD_E, RD_M, RD_W, Rs1_E, Rs2_E, Rs1_D, Rs2_D;

  logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic        sf0, sd0, se0, fd0, fe0, bm0, mb0;
  logic        sf1, sd1, se1, fd1, fe1, bm1, mb1;
  logic        sf2, sd2, se2, fd2, fe2, bm2, mb2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(3), .ZERO_REG(1), .MC_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .ForwardAE(fa0), .ForwardBE(fb0),
    .StallF(sf0), .StallD(sd0), .StallE(se0), .FlushD(fd0), .FlushE(fe0),
    .BubbleM(bm0), .McBusy(mb0), .StallCount(sc0), .FlushCount(fc0));

  hazard_unit_mc #(.REG_AW(3), .ZERO_REG(1), .MC_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .FlushD(fd1), .FlushE(fe1),
    .BubbleM(bm1), .McBusy(mb1), .StallCount(sc1), .FlushCount(fc1));

  hazard_unit_mc #(.REG_AW(3), .ZERO_REG(1), .MC_LAT(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .ForwardAE(fa2), .ForwardBE(fb2),
    .StallF(sf2), .StallD(sd2), .StallE(se2), .FlushD(fd2), .FlushE(fe2),
    .BubbleM(bm2), .McBusy(mb2), .StallCount(sc2), .FlushCount(fc2));

  // Inputs change just after a negedge; outputs are sampled 1 time unit later.
  task automatic clear_inputs();
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; MultiCycleE = 0; PCSrcE = 0;
    RD_E = 0; RD_M = 0; RD_W = 0; Rs1_E = 0; Rs2_E = 0; Rs1_D = 0; Rs2_D = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    RegWriteM = 1; RD_M = 3; Rs1_E = 3; PCSrcE = 1;
    ResultSrcE = 1; RD_E = 2; Rs1_D = 2; MultiCycleE = 1;
    #1;
    checks++; if ({fa0, sf0, sd0, se0, fd0, fe0, bm0, mb0} !== 9'd0) begin
      $display("FAIL reset_outputs: got %b expected 0", {fa0, sf0, sd0, se0, fd0, fe0, bm0, mb0}); errors++; end
    next_cycle();
    rst = 0; clear_inputs(); #1;
    checks++; if (sc0 !== 16'd0 || fc0 !== 16'd0 || mb0 !== 1'b0) begin
      $display("FAIL reset_state: got sc=%0d fc=%0d busy=%0d expected 0 0 0", sc0, fc0, mb0); errors++; end
  endtask

  task automatic test_forward();
    apply_reset();
    RegWriteM = 1; RegWriteW = 1; RD_M = 3; RD_W = 3; Rs1_E = 3; Rs2_E = 5; #1;
    checks++; if (fa0 !== 2'b10) begin $display("FAIL fwd_m_prio: got %b expected 10", fa0); errors++; end
    checks++; if (fb0 !== 2'b00) begin $display("FAIL fwd_b_none: got %b expected 00", fb0); errors++; end
    RegWriteM = 0; #1;
    checks++; if (fa0 !== 2'b01) begin $display("FAIL fwd_w: got %b expected 01", fa0); errors++; end
    RegWriteM = 1; RD_M = 5; #1;
    checks++; if (fa0 !== 2'b01 || fb0 !== 2'b10) begin
      $display("FAIL fwd_split: got a=%b b=%b expected a=01 b=10", fa0, fb0); errors++; end
  endtask

  task automatic test_zero_reg();
    apply_reset();
    RegWriteM = 1; RD_M = 0; Rs1_E = 0; #1;
    checks++; if (fa0 !== 2'b00) begin $display("FAIL zero_fwd: got %b expected 00", fa0); errors++; end
    clear_inputs(); ResultSrcE = 1; RD_E = 0; Rs1_D = 0; #1;
    checks++; if (sf0 !== 1'b0 || fe0 !== 1'b0) begin
      $display("FAIL zero_lu: got stallf=%0d flushe=%0d expected 0 0", sf0, fe0); errors++; end
  endtask

  task automatic test_load_use();
    apply_reset();
    ResultSrcE = 1; RD_E = 2; Rs1_D = 1; Rs2_D = 2; #1;
    checks++; if ({sf0, sd0, fe0, se0, bm0} !== 5'b11100) begin
      $display("FAIL lu_outputs: got %b expected 11100", {sf0, sd0, fe0, se0, bm0}); errors++; end
    checks++; if (sc0 !== 16'd0) begin $display("FAIL lu_cnt_before: got %0d expected 0", sc0); errors++; end
    next_cycle(); clear_inputs(); #1;
    checks++; if (sc0 !== 16'd1 || sf0 !== 1'b0) begin
      $display("FAIL lu_cnt_after: got cnt=%0d stallf=%0d expected 1 0", sc0, sf0); errors++; end
  endtask

  task automatic test_multicycle();
    logic [3:0] exp_stall;
    logic [3:0] exp_busy;
    exp_stall = 4'b1110;
    exp_busy  = 4'b0111;
    apply_reset();
    MultiCycleE = 1; #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sf0 !== exp_stall[3-i] || se0 !== exp_stall[3-i] || bm0 !== exp_stall[3-i] || mb0 !== exp_busy[3-i]) begin
        $display("FAIL mc_cycle%0d: got stallf=%0d stalle=%0d bubble=%0d busy=%0d expected %0d %0d %0d %0d",
                 i + 1, sf0, se0, bm0, mb0, exp_stall[3-i], exp_stall[3-i], exp_stall[3-i], exp_busy[3-i]); errors++; end
      checks++; if (sf1 !== 1'b0 || mb1 !== 1'b0) begin
        $display("FAIL mc_lat1_cycle%0d: got stallf=%0d busy=%0d expected 0 0", i + 1, sf1, mb1); errors++; end
      next_cycle();
    end
    MultiCycleE = 0; #1;
    checks++; if (mb0 !== 1'b0 || sf0 !== 1'b0) begin
      $display("FAIL mc_idle5: got busy=%0d stallf=%0d expected 0 0", mb0, sf0); errors++; end
    checks++; if (sc0 !== 16'd3) begin $display("FAIL mc_stallcount: got %0d expected 3", sc0); errors++; end
    checks++; if (sc1 !== 16'd0) begin $display("FAIL mc_lat1_count: got %0d expected 0", sc1); errors++; end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    MultiCycleE = 1; #1;
    for (int i = 0; i < 4; i++) next_cycle();
    checks++; if (sf0 !== 1'b1 || mb0 !== 1'b0) begin
      $display("FAIL b2b_redetect: got stallf=%0d busy=%0d expected 1 0", sf0, mb0); errors++; end
    next_cycle();
    checks++; if (mb0 !== 1'b1 || sc0 !== 16'd4) begin
      $display("FAIL b2b_second: got busy=%0d cnt=%0d expected 1 4", mb0, sc0); errors++; end
  endtask

  task automatic test_branch_vs_mc();
    apply_reset();
    PCSrcE = 1; MultiCycleE = 1; #1;
    checks++; if ({fd0, fe0, sf0, se0} !== 4'b1100) begin
      $display("FAIL br_outputs: got %b expected 1100", {fd0, fe0, sf0, se0}); errors++; end
    next_cycle(); clear_inputs(); #1;
    checks++; if (mb0 !== 1'b0 || fc0 !== 16'd1) begin
      $display("FAIL br_state: got busy=%0d flushcnt=%0d expected 0 1", mb0, fc0); errors++; end
  endtask

  task automatic test_saturation();
    apply_reset();
    ResultSrcE = 1; RD_E = 4; Rs1_D = 4; #1;
    for (int i = 0; i < 5; i++) next_cycle();
    clear_inputs(); #1;
    checks++; if (sc2 !== 2'd3) begin $display("FAIL sat_cnt2: got %0d expected 3", sc2); errors++; end
    checks++; if (sc0 !== 16'd5) begin $display("FAIL sat_cnt16: got %0d expected 5", sc0); errors++; end
    PCSrcE = 1; #1;
    for (int i = 0; i < 4; i++) next_cycle();
    PCSrcE = 0; #1;
    checks++; if (fc2 !== 2'd3 || fc0 !== 16'd4) begin
      $display("FAIL sat_flush: got fc2=%0d fc16=%0d expected 3 4", fc2, fc0); errors++; end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    MultiCycleE = 1; #1;
    next_cycle();
    next_cycle();
    checks++; if (mb0 !== 1'b1) begin $display("FAIL rmb_busy: got %0d expected 1", mb0); errors++; end
    rst = 1; MultiCycleE = 0; #1;
    checks++; if ({sf0, se0, bm0, mb0} !== 4'b0000) begin
      $display("FAIL rmb_during: got %b expected 0000", {sf0, se0, bm0, mb0}); errors++; end
    next_cycle();
    rst = 0; #1;
    checks++; if ({mb0, sf0, sd0, se0, bm0, fd0, fe0} !== 7'd0 || sc0 !== 16'd0 || fc0 !== 16'd0) begin
      $display("FAIL rmb_after: got outs=%b sc=%0d fc=%0d expected 0 0 0",
               {mb0, sf0, sd0, se0, bm0, fd0, fe0}, sc0, fc0); errors++; end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_forward();
    test_zero_reg();
    test_load_use();
    test_multicycle();
    test_back_to_back();
    test_branch_vs_mc();
    test_saturation();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the 5-stage pipeline's hazard/forwarding unit.
- Adds register-address width and zero-register parameters.
- Adds a multi-cycle execute FSM that holds the E stage for MC_LAT cycles.
- Adds an E-stage stall with a bubble into M, plus saturating stall/flush performance counters.
- Sits beside the fetch/decode/execute/memory/writeback stages and drives their stall, flush and forward selects.

Parameters:
- REG_AW, 3, register address width.
- ZERO_REG, 1, if 1 then register 0 never matches for forwarding or hazards.
- MC_LAT, 4, E-stage occupancy in cycles for a multi-cycle op. Must be ≥ 1; 1 means a single-cycle op.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- RegWriteM  in  1  M-stage instruction writes a register.
- RegWriteW  in  1  W-stage instruction writes a register.
- ResultSrcE  in  1  E-stage instruction is a load.
- MultiCycleE  in  1  E-stage instruction is a multi-cycle op.
- PCSrcE  in  1  branch/jump taken in E.
- RD_E, RD_M, RD_W  in  REG_AW  destination registers of E, M and W.
- Rs1_E, Rs2_E  in  REG_AW  E-stage source registers.
- Rs1_D, Rs2_D  in  REG_AW  D-stage source registers.
- ForwardAE, ForwardBE  out  2  forward selects: 00 = register file, 01 = W, 10 = M.
- StallF, StallD, StallE  out  1  hold the PC, the D register and the E register.
- FlushD, FlushE  out  1  clear the D and E pipeline registers.
- BubbleM  out  1  clear the E/M register (insert a nop into M).
- McBusy  out  1  FSM is in the BUSY state.
- StallCount, FlushCount  out  CNT_W  performance counters.

Behaviour:
- Reset
  - Synchronous: state = IDLE, cnt = 0, StallCount = 0, FlushCount = 0.
  - While rst = 1, every combinational output is forced to 0.
- Register matching
  - match(a, b) = (a == b) && !(ZERO_REG && a == 0).
- Forwarding (combinational, per source; ForwardAE uses Rs1_E, ForwardBE uses Rs2_E)
  - 10 if RegWriteM && match(RD_M, Rs).
  - else 01 if RegWriteW && match(RD_W, Rs).
  - else 00.
  - M has priority over W.
- Load-use hazard
  - lu = ResultSrcE && (match(RD_E, Rs1_D) || match(RD_E, Rs2_D)).
- FSM states: IDLE and BUSY; cnt is width clog2(MC_LAT)+1.
  - IDLE → BUSY when MultiCycleE && !PCSrcE && MC_LAT > 1; cnt <= MC_LAT-2.
  - BUSY with cnt != 0: cnt <= cnt-1.
  - BUSY with cnt == 0: go to IDLE; the op leaves E at this edge.
- Multi-cycle stall
  - mc = (IDLE && MultiCycleE && !PCSrcE && MC_LAT > 1) || (BUSY && cnt != 0).
  - The op therefore occupies E for exactly MC_LAT cycles, with MC_LAT-1 stall cycles.
  - A back-to-back multi-cycle op is re-detected in IDLE on the next cycle.
- Output equations
  - StallF = mc | lu.
  - StallD = mc | lu.
  - StallE = mc.
  - BubbleM = mc.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | (lu & !mc).
  - McBusy = (state == BUSY).
- Priority
  - PCSrcE beats a multi-cycle start.
  - mc suppresses the load-use FlushE, so E is held rather than cleared.
  - lu && MultiCycleE together is illegal; the equations above still define the outputs.
- Counters
  - StallCount += 1 on each cycle with StallF = 1.
  - FlushCount += 1 on each cycle with PCSrcE = 1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-BUSY
  - The next cycle is IDLE and all stalls are 0; the held op is discarded by the stage resets.

Test Plan:
- Forward priority:
  - Stimulus: RegWriteM = RegWriteW = 1, RD_M = RD_W = 3, Rs1_E = 3, Rs2_E = 5.
  - Response: ForwardAE = 10, ForwardBE = 00. Then set RegWriteM = 0 → ForwardAE = 01.
- Zero register:
  - Stimulus: RegWriteM = 1, RD_M = 0, Rs1_E = 0, ZERO_REG = 1.
  - Response: ForwardAE = 00.
  - Stimulus: ResultSrcE = 1, RD_E = 0, Rs1_D = 0.
  - Response: no stall.
- Load-use:
  - Stimulus: ResultSrcE = 1, RD_E = 2, Rs2_D = 2 for 1 cycle.
  - Response: StallF = StallD = FlushE = 1, StallE = 0, StallCount 0 → 1.
- Multi-cycle:
  - Stimulus: MC_LAT = 4, MultiCycleE held high for 4 cycles.
  - Response: StallF/StallE/BubbleM = 1,1,1,0; McBusy = 0,1,1,1; IDLE on the 5th cycle; StallCount = 3.
  - Repeat with MC_LAT = 1: no stall at all.
- Branch vs. multi-cycle:
  - Stimulus: PCSrcE = 1 and MultiCycleE = 1 in IDLE.
  - Response: FlushD = FlushE = 1, StallF = 0, stays IDLE, FlushCount += 1.
- Saturation and reset:
  - CNT_W = 2: 5 consecutive stall cycles → StallCount = 3.
  - rst = 1 in the 2nd BUSY cycle → next cycle McBusy = 0, all outputs 0, counters 0.
